in_port: RTL and testbench

- Input-side counterpart of the 7-segment output block. It captures a 16-bit operand from the board DIP switches when the operator presses the enter pushbutton.
- It returns that operand to the processor core through a request/valid handshake that serves the IN instruction.
- It sits between the board I/O pins and the core's register-write path, in the same clock domain as the display block.

---
 rtl/in_port_pkg.sv | 21 ++
 rtl/in_port_btn_debounce.sv | 55 +++++
 rtl/in_port.sv | 158 +++++++++++++++
 tb/tb_in_port.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/in_port_pkg.sv
// Package for the in_port block.
// Holds the FSM state encoding and the default constants shared by in_port
// and its debounce sub-module.
// Optional feature macro: IN_TYPEAHEAD_EN (the type-ahead depth default lives here).
package in_port_pkg;

  // Request-serving FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // 10 ms of stable button level at 50 MHz.
  localparam int DB_LIMIT_DEFAULT = 500000;

  // Type-ahead FIFO depth used when IN_TYPEAHEAD_EN is defined.
  localparam int TA_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/in_port_btn_debounce.sv
// btn_debounce: turns the raw, bouncing enter pushbutton into a clean
// one-cycle press pulse.
// Ports:
//   clock  in  system clock (rising edge)
//   reset  in  asynchronous active-low reset
//   btn    in  raw pushbutton level, asynchronous, active-high
//   press  out one-cycle pulse per accepted 0->1 transition of the button
// The raw level passes through a 2-flop synchroniser. A change is accepted
// only after the synchronised level has disagreed with the accepted level
// for DB_LIMIT consecutive cycles; any return to the accepted level restarts
// the count. The press pulse is registered, one cycle after acceptance.
module btn_debounce
  import in_port_pkg::*;
#(
  parameter int DB_CNT_W = 20,
  parameter int DB_LIMIT = DB_LIMIT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_LIMIT - 1);
  localparam logic [DB_CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0]          btn_sync;
  logic                acc_lvl;
  logic                acc_lvl_d;
  logic [DB_CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_sync  <= 2'b00;
      acc_lvl   <= 1'b0;
      acc_lvl_d <= 1'b0;
      cnt       <= '0;
      press     <= 1'b0;
    end else begin
      btn_sync  <= {btn_sync[0], btn};
      acc_lvl_d <= acc_lvl;
      press     <= acc_lvl & ~acc_lvl_d;
      if (btn_sync[1] == acc_lvl) begin
        // Nothing pending (or a bounce returned to the accepted level).
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        acc_lvl <= btn_sync[1];
        cnt     <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/in_port.sv
// in_port: captures a DIP-switch operand on an enter-button press and hands
// it to the core for the IN instruction.
// Ports:
//   clock     in  system clock (rising edge)
//   reset     in  asynchronous active-low reset
//   sw        in  raw DIP switch levels (asynchronous)
//   btn       in  raw enter pushbutton (asynchronous, bouncing)
//   in_req    in  request level from the core, held while IN is stalled
//   in_data   out captured operand, held until the next capture
//   in_valid  out one-cycle pulse, in_data valid this cycle
//   in_wait   out request pending with no operand yet ("waiting" LED)
//   state_dbg out current FSM state
// Handshake: the core raises in_req and holds it; in_port answers with a
// single in_valid cycle carrying in_data; the core drops in_req the cycle
// after it samples in_valid, and a new operand is only produced for a new
// request. Dropping in_req while waiting withdraws the request.
// Optional feature macro: IN_TYPEAHEAD_EN -- presses in any state are queued
// in a TA_DEPTH-entry FIFO and served to later requests.
module in_port
  import in_port_pkg::*;
#(
  parameter int DATA_W   = 16,
`ifdef IN_TYPEAHEAD_EN
  parameter int TA_DEPTH = TA_DEPTH_DEFAULT,
`endif
  parameter int DB_CNT_W = 20,
  parameter int DB_LIMIT = DB_LIMIT_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] sw,
  input  logic              btn,
  input  logic              in_req,
  output logic [DATA_W-1:0] in_data,
  output logic              in_valid,
  output logic              in_wait,
  output state_t            state_dbg
);

  state_t            state;
  state_t            state_n;
  logic [DATA_W-1:0] sw_s1;
  logic [DATA_W-1:0] sw_s2;
  logic              press;
  logic              take;     // an operand is available to a waiting request
  logic              capture;  // load in_data this cycle
  logic [DATA_W-1:0] cap_val;

  btn_debounce #(
    .DB_CNT_W (DB_CNT_W),
    .DB_LIMIT (DB_LIMIT)
  ) u_btn_debounce (
    .clock (clock),
    .reset (reset),
    .btn   (btn),
    .press (press)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
    end
  end

`ifdef IN_TYPEAHEAD_EN
  localparam int TA_AW = (TA_DEPTH > 1) ? $clog2(TA_DEPTH) : 1;
  localparam int TA_CW = TA_AW + 1;

  logic [DATA_W-1:0] ta_mem [TA_DEPTH];
  logic [TA_AW-1:0]  ta_rd;
  logic [TA_AW-1:0]  ta_wr;
  logic [TA_CW-1:0]  ta_cnt;
  logic              ta_push;
  logic              ta_pop;
  logic              ta_full;
  logic              ta_empty;

  assign ta_full  = (ta_cnt == TA_CW'(TA_DEPTH));
  assign ta_empty = (ta_cnt == '0);
  // A press into a full FIFO is dropped, leaving its contents untouched.
  assign ta_push  = press & ~ta_full;
  assign ta_pop   = capture;
  assign take     = ~ta_empty;
  assign cap_val  = ta_mem[ta_rd];

  always_ff @(posedge clock) begin
    if (ta_push) ta_mem[ta_wr] <= sw_s2;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ta_rd  <= '0;
      ta_wr  <= '0;
      ta_cnt <= '0;
    end else begin
      if (ta_push) ta_wr <= (ta_wr == TA_AW'(TA_DEPTH - 1)) ? '0 : ta_wr + 1'b1;
      if (ta_pop)  ta_rd <= (ta_rd == TA_AW'(TA_DEPTH - 1)) ? '0 : ta_rd + 1'b1;
      case ({ta_push, ta_pop})
        2'b10:   ta_cnt <= ta_cnt + 1'b1;
        2'b01:   ta_cnt <= ta_cnt - 1'b1;
        default: ta_cnt <= ta_cnt;
      endcase
    end
  end
`else
  // Without type-ahead only a press seen while waiting counts.
  assign take    = press;
  assign cap_val = sw_s2;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic. A withdrawn request wins over a same-cycle operand.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_req) state_n = WAIT;
      WAIT: begin
        if (!in_req)   state_n = IDLE;
        else if (take) state_n = VALID;
      end
      VALID:   state_n = HOLD;
      HOLD:    if (!in_req) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    in_wait  = 1'b0;
    in_valid = 1'b0;
    capture  = 1'b0;
    case (state)
      WAIT: begin
        in_wait = 1'b1;
        capture = in_req & take;
      end
      VALID:   in_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       in_data <= '0;
    else if (capture) in_data <= cap_val;
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_in_port.sv
`timescale 1ns/1ps
module tb_in_port;
  import in_port_pkg::*;

  localparam int DATA_W   = 16;
  localparam int DB_LIMIT = 4;
  localparam int LAT      = 2 + 2 + DB_LIMIT;  // clean btn rise to in_valid
`ifdef IN_TYPEAHEAD_EN
  localparam int LAT_WAIT = LAT + 1;           // press is queued, then popped
`else
  localparam int LAT_WAIT = LAT;
`endif
  localparam int TMO = 60;

  // ---------------- clock / reset ----------------
  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] sw = '0;
  logic              btn = 1'b0;
  logic              in_req = 1'b0;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_wait;
  state_t            state_dbg;

  always #5 clock = ~clock;

  in_port #(
    .DATA_W   (DATA_W),
    .DB_CNT_W (20),
    .DB_LIMIT (DB_LIMIT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .sw        (sw),
    .btn       (btn),
    .in_req    (in_req),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_wait   (in_wait),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int                errors = 0;
  int                checks = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] obs_q[$];
  logic [DATA_W-1:0] last_data = '0;
  logic              prev_valid = 1'b0;

  // Every in_valid cycle is recorded; a pulse longer than one cycle is an error.
  always @(negedge clock) begin
    if (in_valid === 1'b1) begin
      obs_q.push_back(in_data);
      checks++;
      if (prev_valid === 1'b1) begin
        errors++;
        $display("FAIL valid_width: in_valid high 2 cycles in a row, required 1");
      end
    end
    prev_valid = in_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 reset = 1'b0;
    sw = '1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      btn = ~btn;
      checks++; if (in_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0000", in_data); end
      checks++; if (in_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", in_valid); end
      checks++; if (in_wait !== 1'b0) begin errors++; $display("FAIL reset_wait: got %b expected 0", in_wait); end
    end
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE); end
    btn = 1'b0; sw = '0;
    reset = 1'b1;
    tick(LAT + 4);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL reset_no_valid: got %0d pulses expected %0d", obs_q.size(), exp_q.size()); end
    checks++; if (in_data !== '0) begin errors++; $display("FAIL reset_idle_data: got %h expected 0000", in_data); end
  endtask

  task automatic test_basic();
    for (int it = 0; it < 5; it++) begin
      logic [DATA_W-1:0] v;
      int hold;
      int lat;
      bit wait_ok;
      v    = (it == 0) ? 16'h9CE5 : DATA_W'($urandom);
      hold = (it == 0) ? 20 : $urandom_range(25, LAT_WAIT + 2);
      sw = v; in_req = 1'b1;
      tick(1);
      checks++; if (in_wait !== 1'b1) begin errors++; $display("FAIL basic_wait_on_req: got %b expected 1", in_wait); end
      tick(2);
      btn = 1'b1; lat = 0; wait_ok = 1'b1;
      while (lat < TMO) begin
        tick(1); lat++;
        if (in_valid === 1'b1) break;
        if (in_wait !== 1'b1) wait_ok = 1'b0;
      end
      checks++; if (lat != LAT_WAIT) begin errors++; $display("FAIL basic_latency: got %0d cycles expected %0d", lat, LAT_WAIT); end
      checks++; if (in_data !== v) begin errors++; $display("FAIL basic_data: got %h expected %h", in_data, v); end
      checks++; if (!wait_ok) begin errors++; $display("FAIL basic_wait_held: in_wait dropped before capture, expected 1"); end
      checks++; if (in_wait !== 1'b0) begin errors++; $display("FAIL basic_wait_at_valid: got %b expected 0", in_wait); end
      exp_q.push_back(v);
      last_data = v;
      in_req = 1'b0; sw = ~v;
      tick(hold - lat);
      btn = 1'b0;
      tick(LAT + 3);
      checks++; if (in_data !== v) begin errors++; $display("FAIL basic_data_hold: got %h expected %h", in_data, v); end
      checks++; if (in_wait !== 1'b0) begin errors++; $display("FAIL basic_wait_after: got %b expected 0", in_wait); end
    end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count: got %0d pulses expected %0d", obs_q.size(), exp_q.size()); end
  endtask

  task automatic test_bounce();
    logic [DATA_W-1:0] v;
    int i;
    int last_rise;
    int run;
    int n0;
    bit lvl;
    v = DATA_W'($urandom);
    sw = v; in_req = 1'b1;
    tick(3);
    n0 = obs_q.size();
    i = 0; last_rise = 0; lvl = 1'b0;
    // Runs shorter than DB_LIMIT must never be accepted.
    while (i < 30) begin
      run = $urandom_range(DB_LIMIT - 1, 1);
      lvl = ~lvl; btn = lvl;
      if (lvl) last_rise = i;
      for (int k = 0; k < run && i < 30; k++) begin tick(1); i++; end
    end
    checks++; if (obs_q.size() != n0) begin errors++; $display("FAIL bounce_quiet: got %0d pulses expected 0", obs_q.size() - n0); end
    if (!lvl) begin btn = 1'b1; last_rise = i; end
    while (i - last_rise < TMO) begin
      tick(1); i++;
      if (in_valid === 1'b1) break;
    end
    checks++; if (i - last_rise != LAT_WAIT) begin errors++; $display("FAIL bounce_latency: got %0d cycles expected %0d", i - last_rise, LAT_WAIT); end
    checks++; if (in_data !== v) begin errors++; $display("FAIL bounce_data: got %h expected %h", in_data, v); end
    exp_q.push_back(v);
    last_data = v;
    in_req = 1'b0;
    tick(5);
    btn = 1'b0;
    tick(LAT + 3);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL bounce_count: got %0d pulses expected %0d", obs_q.size(), exp_q.size()); end
  endtask

  task automatic test_held_two_req();
    int lat;
    int n0;
    sw = 16'h0001; in_req = 1'b1;
    tick(3);
    btn = 1'b1; lat = 0;
    while (lat < TMO) begin tick(1); lat++; if (in_valid === 1'b1) break; end
    checks++; if (lat != LAT_WAIT) begin errors++; $display("FAIL held_first_latency: got %0d expected %0d", lat, LAT_WAIT); end
    checks++; if (in_data !== 16'h0001) begin errors++; $display("FAIL held_first_data: got %h expected 0001", in_data); end
    exp_q.push_back(16'h0001);
    in_req = 1'b0;
    tick(3);
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL held_idle: got %0d expected %0d", state_dbg, IDLE); end
    sw = 16'h0002; in_req = 1'b1;
    n0 = obs_q.size();
    tick(20);
    checks++; if (obs_q.size() != n0) begin errors++; $display("FAIL held_no_second: got %0d pulses expected 0", obs_q.size() - n0); end
    checks++; if (in_wait !== 1'b1) begin errors++; $display("FAIL held_waiting: got %b expected 1", in_wait); end
    btn = 1'b0;
    tick(LAT + 2);
    btn = 1'b1; lat = 0;
    while (lat < TMO) begin tick(1); lat++; if (in_valid === 1'b1) break; end
    checks++; if (lat != LAT_WAIT) begin errors++; $display("FAIL held_second_latency: got %0d expected %0d", lat, LAT_WAIT); end
    checks++; if (in_data !== 16'h0002) begin errors++; $display("FAIL held_second_data: got %h expected 0002", in_data); end
    exp_q.push_back(16'h0002);
    last_data = 16'h0002;
    in_req = 1'b0;
    tick(3);
    btn = 1'b0;
    tick(LAT + 3);
  endtask

  task automatic test_abort();
    in_req = 1'b1;
    tick(10);
    checks++; if (state_dbg !== WAIT) begin errors++; $display("FAIL abort_wait_state: got %0d expected %0d", state_dbg, WAIT); end
    in_req = 1'b0;
    tick(1);
    checks++; if (state_dbg !== IDLE || in_wait !== 1'b0) begin errors++; $display("FAIL abort_idle: got state %0d wait %b expected %0d/0", state_dbg, in_wait, IDLE); end
    tick(10);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL abort_no_valid: got %0d pulses expected %0d", obs_q.size(), exp_q.size()); end
`ifndef IN_TYPEAHEAD_EN
    begin
      logic [DATA_W-1:0] v;
      int lat;
      // A press with no request pending is lost.
      sw = 16'hA5A5; btn = 1'b1;
      tick(LAT + 4);
      btn = 1'b0;
      tick(LAT + 3);
      checks++; if (in_data !== last_data) begin errors++; $display("FAIL idle_press_data: got %h expected %h", in_data, last_data); end
      // Request rises in the very cycle of the press event: press is lost.
      btn = 1'b1;
      tick(LAT - 1);
      in_req = 1'b1;
      tick(20);
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL same_cycle_no_valid: got %0d pulses expected %0d", obs_q.size(), exp_q.size()); end
      checks++; if (in_wait !== 1'b1) begin errors++; $display("FAIL same_cycle_waiting: got %b expected 1", in_wait); end
      btn = 1'b0;
      tick(LAT + 2);
      v = DATA_W'($urandom);
      sw = v; btn = 1'b1; lat = 0;
      while (lat < TMO) begin tick(1); lat++; if (in_valid === 1'b1) break; end
      checks++; if (lat != LAT || in_data !== v) begin errors++; $display("FAIL same_cycle_next_press: got lat %0d data %h expected %0d/%h", lat, in_data, LAT, v); end
      exp_q.push_back(v);
      last_data = v;
      in_req = 1'b0;
      tick(3);
      btn = 1'b0;
      tick(LAT + 3);
    end
`endif
    // Reset while waiting, mid-debounce.
    in_req = 1'b1;
    tick(2);
    btn = 1'b1;
    tick(3);
    checks++; if (in_wait !== 1'b1) begin errors++; $display("FAIL rst_pre_wait: got %b expected 1", in_wait); end
    reset = 1'b0;
    #1;
    checks++; if (in_wait !== 1'b0) begin errors++; $display("FAIL rst_async_wait: got %b expected 0", in_wait); end
    checks++; if (in_data !== '0) begin errors++; $display("FAIL rst_async_data: got %h expected 0000", in_data); end
    btn = 1'b0; in_req = 1'b0;
    tick(2);
    reset = 1'b1;
    last_data = '0;
    tick(LAT + 6);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rst_no_valid: got %0d pulses expected %0d", obs_q.size(), exp_q.size()); end
  endtask

`ifdef IN_TYPEAHEAD_EN
  task automatic test_typeahead();
    for (int k = 1; k <= 5; k++) begin
      sw = DATA_W'(k);
      tick(3);
      btn = 1'b1;
      tick(LAT + 2);
      btn = 1'b0;
      tick(LAT + 2);
    end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL ta_no_valid_idle: got %0d pulses expected %0d", obs_q.size(), exp_q.size()); end
    for (int k = 1; k <= 4; k++) begin
      in_req = 1'b1;
      tick(1);
      checks++; if (in_wait !== 1'b1) begin errors++; $display("FAIL ta_wait_%0d: got %b expected 1", k, in_wait); end
      tick(1);
      checks++; if (in_valid !== 1'b1 || in_data !== DATA_W'(k)) begin errors++; $display("FAIL ta_pop_%0d: got valid %b data %h expected 1/%h", k, in_valid, in_data, DATA_W'(k)); end
      exp_q.push_back(DATA_W'(k));
      in_req = 1'b0;
      tick(3);
    end
    in_req = 1'b1;
    tick(10);
    checks++; if (in_wait !== 1'b1 || obs_q.size() != exp_q.size()) begin errors++; $display("FAIL ta_fifth_dropped: got wait %b pulses %0d expected 1/%0d", in_wait, obs_q.size(), exp_q.size()); end
    in_req = 1'b0;
    tick(3);
  endtask
`endif

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_basic();
    test_bounce();
    test_held_two_req();
    test_abort();
`ifdef IN_TYPEAHEAD_EN
    test_typeahead();
`endif
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL sb_count: got %0d operands expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [DATA_W-1:0] o;
      logic [DATA_W-1:0] e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL sb_data: got %h expected %h", o, e); end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
